// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer for the single-issue core: fetch, decode, execute,
// memory and write-back, one state per cycle, driving all datapath selects and write strobes.
module core_ctrl_fsm #(
  parameter int DataSize = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] instruction,
  input  logic        im_ready,
  input  logic        dm_ready,
  input  logic        alu_zero,
  output logic        im_read,
  output logic        ir_write,
  output logic        dm_read,
  output logic        dm_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic [1:0]  select_pc,
  output logic [1:0]  select_imm_extend,
  output logic [2:0]  alu_src2_select,
  output logic [1:0]  write_reg_select,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_ALU_1 = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b101000;
  localparam logic [5:0] OP_ORI   = 6'b101100;
  localparam logic [5:0] OP_MOVI  = 6'b100010;
  localparam logic [5:0] OP_LWI   = 6'b000010;
  localparam logic [5:0] OP_SWI   = 6'b001010;
  localparam logic [5:0] OP_BR    = 6'b100110;
  localparam logic [5:0] OP_J     = 6'b100100;

  state_t      state_reg;
  logic [31:0] ir_reg;
  logic        illegal_reg;
  logic [1:0]  ext_reg;
  logic [2:0]  src2_reg;
  logic [1:0]  wb_reg;

  logic [1:0]  ext_next;
  logic [2:0]  src2_next;
  logic [1:0]  wb_next;
  logic        op_known;

  logic [5:0]  opcode;
  logic [4:0]  sub_op;
  logic        op_is_wb;
  logic        op_is_lwi;
  logic        op_is_swi;
  logic        op_is_br;
  logic        op_is_j;
  logic        br_taken;

  assign opcode    = ir_reg[30:25];
  assign sub_op    = ir_reg[4:0];
  assign op_is_wb  = (opcode == OP_ALU_1) || (opcode == OP_ADDI) ||
                     (opcode == OP_ORI)   || (opcode == OP_MOVI);
  assign op_is_lwi = (opcode == OP_LWI);
  assign op_is_swi = (opcode == OP_SWI);
  assign op_is_br  = (opcode == OP_BR);
  assign op_is_j   = (opcode == OP_J);
  // IR[14] selects BNE, so taken is simply the condition bit XOR the zero flag
  assign br_taken  = op_is_br && (ir_reg[14] ^ alu_zero);

  // IR fields the controller never decodes, plus the datapath width
  logic unused_bits;
  assign unused_bits = ^{ir_reg[31], ir_reg[24:15], ir_reg[13:5], (DataSize == 32)};

  always_comb begin
    ext_next  = 2'b00;
    src2_next = 3'b000;
    wb_next   = 2'b00;
    op_known  = 1'b1;
    case (opcode)
      OP_ALU_1: begin
        if (sub_op == 5'b01000 || sub_op == 5'b01001 || sub_op == 5'b01011)
          src2_next = 3'b001;
      end
      OP_ADDI: begin
        ext_next  = 2'b01;
        src2_next = 3'b001;
      end
      OP_ORI: begin
        ext_next  = 2'b10;
        src2_next = 3'b001;
      end
      OP_MOVI: begin
        ext_next  = 2'b11;
        src2_next = 3'b001;
        wb_next   = 2'b01;
      end
      OP_LWI: begin
        src2_next = 3'b010;
        wb_next   = 2'b10;
      end
      OP_SWI:  src2_next = 3'b010;
      OP_BR:   src2_next = 3'b100;
      OP_J:    ;
      default: op_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= S_FETCH;
      ir_reg      <= '0;
      illegal_reg <= 1'b0;
      ext_reg     <= 2'b00;
      src2_reg    <= 3'b000;
      wb_reg      <= 2'b00;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (enable && im_ready) begin
            ir_reg      <= instruction;
            illegal_reg <= 1'b0;
            state_reg   <= S_DECODE;
          end
        end
        S_DECODE: begin
          ext_reg     <= ext_next;
          src2_reg    <= src2_next;
          wb_reg      <= wb_next;
          illegal_reg <= !op_known;
          state_reg   <= S_EXEC;
        end
        S_EXEC: begin
          if (op_is_wb)
            state_reg <= S_WB;
          else if (op_is_lwi || op_is_swi)
            state_reg <= S_MEM;
          else
            state_reg <= S_FETCH;
        end
        S_MEM: begin
          if (dm_ready)
            state_reg <= op_is_lwi ? S_WB : S_FETCH;
        end
        S_WB:    state_reg <= S_FETCH;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // Strobes are gated by rst so an access interrupted by reset issues no writes
  always_comb begin
    im_read   = 1'b0;
    ir_write  = 1'b0;
    dm_read   = 1'b0;
    dm_write  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    select_pc = 2'b00;
    if (rst) begin
      case (state_reg)
        S_FETCH: begin
          im_read  = enable;
          ir_write = enable && im_ready;
        end
        S_EXEC: begin
          if (!op_is_wb && !op_is_lwi && !op_is_swi) begin
            pc_write = 1'b1;
            if (br_taken)
              select_pc = 2'b01;
            else if (op_is_j)
              select_pc = 2'b10;
          end
        end
        S_MEM: begin
          dm_read  = op_is_lwi;
          dm_write = op_is_swi;
          pc_write = op_is_swi && dm_ready;
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign select_imm_extend = ext_reg;
  assign alu_src2_select   = src2_reg;
  assign write_reg_select  = wb_reg;
  assign illegal           = illegal_reg;
  assign state             = state_reg;

endmodule
